// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - icache/dcache memory bus arbiter with load-tag return routing
// Optional ICACHE_STARVE_GUARD_EN lets icache win after three consecutive dcache wins while it waits.
module mem_bus_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [1:0]      icache_command,
   input  logic [XLEN-1:0] icache_addr,
   input  logic [1:0]      dcache_command,
   input  logic [XLEN-1:0] dcache_addr,
   output logic            icache_ack,
   output logic            dcache_ack,
   output logic [3:0]      ack_tag,
   output logic [1:0]      proc2mem_command,
   output logic [XLEN-1:0] proc2mem_addr,
   input  logic [3:0]      mem2proc_response,
   input  logic [63:0]     mem2proc_data,
   input  logic [3:0]      mem2proc_tag,
   output logic            icache_data_valid,
   output logic            dcache_data_valid,
   output logic [63:0]     cache_data,
   output logic [3:0]      cache_tag,
   output logic [4:0]      outstanding_cnt
);

   // Bus command encoding: 0 none, 1 load, 2 store.
   localparam logic [1:0] BUS_NONE   = 2'd0;
   localparam logic [1:0] BUS_LOAD   = 2'd1;
   localparam logic [1:0] OWN_NONE   = 2'd0;
   localparam logic [1:0] OWN_ICACHE = 2'd1;
   localparam logic [1:0] OWN_DCACHE = 2'd2;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        cmd_q, cmd_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [15:0][1:0]  table_q, table_d;
   logic [4:0]        cnt_q, cnt_d;

   logic       icache_req, dcache_req, pick_icache;
   logic       load_grant, ret_hit;
   logic [1:0] ret_owner;

   assign icache_req      = (icache_command != BUS_NONE);
   assign dcache_req      = (dcache_command != BUS_NONE);
   assign outstanding_cnt = cnt_q;

`ifdef ICACHE_STARVE_GUARD_EN
   logic [1:0] starve_q, starve_d;

   assign pick_icache = icache_req && (!dcache_req || (starve_q == 2'd3));

   // Counts dcache wins while icache is left waiting; any other outcome breaks the streak.
   always_comb begin
      starve_d = starve_q;
      if ((state_q == IDLE) && (icache_req || dcache_req)) begin
         if (pick_icache)
            starve_d = 2'd0;
         else if (icache_req)
            starve_d = starve_q + 2'd1;
         else
            starve_d = 2'd0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         starve_q <= 2'd0;
      else
         starve_q <= starve_d;
   end
`else
   assign pick_icache = icache_req && !dcache_req;
`endif

   always_comb begin
      state_d          = state_q;
      owner_d          = owner_q;
      cmd_d            = cmd_q;
      addr_d           = addr_q;
      table_d          = table_q;
      cnt_d            = cnt_q;
      icache_ack       = 1'b0;
      dcache_ack       = 1'b0;
      ack_tag          = 4'd0;
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      load_grant       = 1'b0;

      case (state_q)
         IDLE: begin
            if (icache_req || dcache_req) begin
               state_d = ISSUE;
               if (pick_icache) begin
                  owner_d = OWN_ICACHE;
                  cmd_d   = icache_command;
                  addr_d  = icache_addr;
               end else begin
                  owner_d = OWN_DCACHE;
                  cmd_d   = dcache_command;
                  addr_d  = dcache_addr;
               end
            end
         end
         ISSUE: begin
            proc2mem_command = cmd_q;
            proc2mem_addr    = addr_q;
            if (mem2proc_response != 4'd0) begin
               icache_ack = (owner_q == OWN_ICACHE);
               dcache_ack = (owner_q == OWN_DCACHE);
               ack_tag    = mem2proc_response;
               load_grant = (cmd_q == BUS_LOAD);
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      ret_owner         = table_q[mem2proc_tag];
      ret_hit           = (mem2proc_tag != 4'd0) && (ret_owner != OWN_NONE);
      cache_tag         = mem2proc_tag;
      cache_data        = (mem2proc_tag != 4'd0) ? mem2proc_data : 64'd0;
      icache_data_valid = ret_hit && (ret_owner == OWN_ICACHE);
      dcache_data_valid = ret_hit && (ret_owner == OWN_DCACHE);

      // Grant write comes after the clear so a same-tag grant keeps the new owner.
      if (ret_hit)
         table_d[mem2proc_tag] = OWN_NONE;
      if (load_grant)
         table_d[mem2proc_response] = owner_q;

      if (load_grant && !ret_hit) begin
         if (cnt_q != 5'd15)
            cnt_d = cnt_q + 5'd1;
      end else if (ret_hit && !load_grant) begin
         if (cnt_q != 5'd0)
            cnt_d = cnt_q - 5'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= OWN_NONE;
         cmd_q   <= BUS_NONE;
         addr_q  <= '0;
         table_q <= '0;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         table_q <= table_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
   localparam logic [1:0] NONE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] STORE = 2'd2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  icache_command, dcache_command, proc2mem_command;
   logic [31:0] icache_addr, dcache_addr, proc2mem_addr;
   logic        icache_ack, dcache_ack, icache_data_valid, dcache_data_valid;
   logic [3:0]  ack_tag, mem2proc_response, mem2proc_tag, cache_tag;
   logic [63:0] mem2proc_data, cache_data;
   logic [4:0]  outstanding_cnt;

   mem_bus_arbiter #(.XLEN(32)) dut (
      .clock(clock), .reset(reset),
      .icache_command(icache_command), .icache_addr(icache_addr),
      .dcache_command(dcache_command), .dcache_addr(dcache_addr),
      .icache_ack(icache_ack), .dcache_ack(dcache_ack), .ack_tag(ack_tag),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
      .mem2proc_tag(mem2proc_tag),
      .icache_data_valid(icache_data_valid), .dcache_data_valid(dcache_data_valid),
      .cache_data(cache_data), .cache_tag(cache_tag), .outstanding_cnt(outstanding_cnt)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

`ifdef ICACHE_STARVE_GUARD_EN
   bit guard = 1'b1;
`else
   bit guard = 1'b0;
`endif

   // Transaction-level reference: one pending request, a tag->owner map and a clamped load count.
   bit          m_busy;
   int          m_owner;   // 1 icache, 2 dcache
   logic [1:0]  m_cmd;
   logic [31:0] m_addr;
   int          m_tab[16];
   int          m_cnt;
   int          m_starve;

   logic        e_iack, e_dack, e_ival, e_dval;
   logic [3:0]  e_tag, e_ctag;
   logic [1:0]  e_cmd;
   logic [31:0] e_addr;
   logic [63:0] e_cdata;

   function automatic void model_reset();
      m_busy = 0; m_owner = 0; m_cmd = NONE; m_addr = 0; m_cnt = 0; m_starve = 0;
      for (int i = 0; i < 16; i++) m_tab[i] = 0;
   endfunction

   function automatic void model_comb();
      bit granted;
      granted = m_busy && (mem2proc_response != 0);
      e_cmd   = m_busy ? m_cmd : NONE;
      e_addr  = m_busy ? m_addr : 32'd0;
      e_iack  = granted && (m_owner == 1);
      e_dack  = granted && (m_owner == 2);
      e_tag   = granted ? mem2proc_response : 4'd0;
      e_ctag  = mem2proc_tag;
      e_cdata = (mem2proc_tag != 0) ? mem2proc_data : 64'd0;
      e_ival  = (mem2proc_tag != 0) && (m_tab[mem2proc_tag] == 1);
      e_dval  = (mem2proc_tag != 0) && (m_tab[mem2proc_tag] == 2);
   endfunction

   function automatic void model_seq();
      bit granted, lg, ret, take_i;
      granted = m_busy && (mem2proc_response != 0);
      lg      = granted && (m_cmd == LOAD);
      ret     = (mem2proc_tag != 0) && (m_tab[mem2proc_tag] != 0);
      if (ret) m_tab[mem2proc_tag] = 0;
      if (lg)  m_tab[mem2proc_response] = m_owner;
      if (lg && !ret)      m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      else if (ret && !lg) m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
      if (granted) begin
         m_busy = 0;
      end else if (!m_busy && (icache_command != NONE || dcache_command != NONE)) begin
         take_i = (icache_command != NONE) &&
                  ((dcache_command == NONE) || (guard && m_starve == 3));
         m_busy = 1;
         if (take_i) begin
            m_owner = 1; m_cmd = icache_command; m_addr = icache_addr; m_starve = 0;
         end else begin
            m_owner = 2; m_cmd = dcache_command; m_addr = dcache_addr;
            m_starve = (icache_command != NONE) ? m_starve + 1 : 0;
         end
      end
   endfunction

   task automatic cyc(input logic [1:0] ic, input logic [31:0] ia, input logic [1:0] dc,
                      input logic [31:0] da, input logic [3:0] rsp, input logic [3:0] tg,
                      input logic [63:0] dt);
      icache_command = ic; icache_addr = ia; dcache_command = dc; dcache_addr = da;
      mem2proc_response = rsp; mem2proc_tag = tg; mem2proc_data = dt;
      model_comb();
      @(negedge clock);
   endtask

   task automatic adv();
      @(posedge clock);
      model_seq();
      #1;
   endtask

   task automatic test_reset();
      icache_command = LOAD; icache_addr = 32'h11; dcache_command = LOAD; dcache_addr = 32'h22;
      mem2proc_response = 4'd3; mem2proc_tag = 4'd3; mem2proc_data = 64'h99;
      #1 reset = 1'b1;
      #1;
      total++; if (proc2mem_command !== NONE) begin bad++; $display("FAIL rst_cmd got=%0d exp=0", proc2mem_command); end
      total++; if (proc2mem_addr !== 32'd0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", proc2mem_addr); end
      total++; if ({icache_ack, dcache_ack} !== 2'b00) begin bad++; $display("FAIL rst_ack got=%b exp=00", {icache_ack, dcache_ack}); end
      total++; if (ack_tag !== 4'd0) begin bad++; $display("FAIL rst_ack_tag got=%0d exp=0", ack_tag); end
      total++; if (outstanding_cnt !== 5'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", outstanding_cnt); end
      total++; if ({icache_data_valid, dcache_data_valid} !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b exp=00", {icache_data_valid, dcache_data_valid}); end
      total++; if (cache_tag !== 4'd3) begin bad++; $display("FAIL rst_cache_tag got=%0d exp=3", cache_tag); end
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_priority_retry();
      cyc(LOAD, 32'h100, LOAD, 32'h200, 0, 0, 0);
      total++; if (proc2mem_command !== NONE || proc2mem_addr !== 0) begin bad++; $display("FAIL idle_drive got=%0d/%0h exp=0/0", proc2mem_command, proc2mem_addr); end
      adv();
      cyc(LOAD, 32'h100, LOAD, 32'h200, 3, 0, 0);
      total++; if (proc2mem_addr !== 32'h200) begin bad++; $display("FAIL prio_addr got=%0h exp=200", proc2mem_addr); end
      total++; if (dcache_ack !== 1'b1 || icache_ack !== 1'b0) begin bad++; $display("FAIL prio_ack got=i%b d%b exp=i0 d1", icache_ack, dcache_ack); end
      total++; if (ack_tag !== 4'd3) begin bad++; $display("FAIL prio_ack_tag got=%0d exp=3", ack_tag); end
      adv();
      cyc(LOAD, 32'h100, NONE, 0, 0, 3, 64'hDEAD_BEEF);
      total++; if (outstanding_cnt !== 5'd1) begin bad++; $display("FAIL load_cnt got=%0d exp=1", outstanding_cnt); end
      total++; if (dcache_data_valid !== 1'b1 || icache_data_valid !== 1'b0) begin bad++; $display("FAIL ret_valid got=i%b d%b exp=i0 d1", icache_data_valid, dcache_data_valid); end
      total++; if (cache_data !== 64'hDEAD_BEEF) begin bad++; $display("FAIL ret_data got=%0h exp=deadbeef", cache_data); end
      adv();
      for (int k = 0; k < 3; k++) begin
         cyc(LOAD, 32'h100, NONE, 0, (k == 2) ? 4'd5 : 4'd0, 0, 0);
         total++; if (proc2mem_command !== LOAD || proc2mem_addr !== 32'h100) begin bad++; $display("FAIL retry_hold k=%0d got=%0d/%0h exp=1/100", k, proc2mem_command, proc2mem_addr); end
         total++; if (icache_ack !== (k == 2) || ack_tag !== ((k == 2) ? 4'd5 : 4'd0)) begin bad++; $display("FAIL retry_ack k=%0d got=%b/%0d", k, icache_ack, ack_tag); end
         if (k == 0) begin
            total++; if (outstanding_cnt !== 5'd0) begin bad++; $display("FAIL ret_cnt got=%0d exp=0", outstanding_cnt); end
         end
         adv();
      end
   endtask

   task automatic test_tag_overlap();
      cyc(NONE, 0, LOAD, 32'h300, 0, 0, 0); adv();
      cyc(NONE, 0, LOAD, 32'h300, 7, 0, 0); adv();
      cyc(LOAD, 32'h400, NONE, 0, 0, 0, 0); adv();
      cyc(LOAD, 32'h400, NONE, 0, 7, 7, 64'h1234);
      total++; if (icache_ack !== 1'b1 || dcache_data_valid !== 1'b1 || icache_data_valid !== 1'b0) begin bad++; $display("FAIL same_tag got=ack%b dv%b iv%b exp=1 1 0", icache_ack, dcache_data_valid, icache_data_valid); end
      total++; if (outstanding_cnt !== 5'd2) begin bad++; $display("FAIL same_tag_cnt_pre got=%0d exp=2", outstanding_cnt); end
      adv();
      cyc(NONE, 0, NONE, 0, 0, 7, 64'h55);
      total++; if (icache_data_valid !== 1'b1 || outstanding_cnt !== 5'd2) begin bad++; $display("FAIL same_tag_owner got=iv%b cnt%0d exp=1 2", icache_data_valid, outstanding_cnt); end
      adv();
      cyc(NONE, 0, NONE, 0, 0, 9, 64'hAA);
      total++; if ({icache_data_valid, dcache_data_valid} !== 2'b00 || cache_tag !== 4'd9 || cache_data !== 64'hAA) begin bad++; $display("FAIL stray_ret got=%b tag%0d data%0h", {icache_data_valid, dcache_data_valid}, cache_tag, cache_data); end
      adv();
      cyc(NONE, 0, NONE, 0, 0, 0, 64'hFF);
      total++; if (cache_data !== 64'd0 || cache_tag !== 4'd0 || outstanding_cnt !== 5'd1) begin bad++; $display("FAIL quiet got=data%0h tag%0d cnt%0d exp=0 0 1", cache_data, cache_tag, outstanding_cnt); end
      adv();
      cyc(NONE, 0, LOAD, 32'h500, 0, 0, 0); adv();
      cyc(NONE, 0, LOAD, 32'h500, 8, 5, 64'h77);
      total++; if (dcache_ack !== 1'b1 || icache_data_valid !== 1'b1) begin bad++; $display("FAIL diff_tag got=ack%b iv%b exp=1 1", dcache_ack, icache_data_valid); end
      adv();
      cyc(NONE, 0, STORE, 32'h600, 0, 0, 0); adv();
      cyc(NONE, 0, STORE, 32'h600, 6, 0, 0);
      total++; if (dcache_ack !== 1'b1 || ack_tag !== 4'd6 || proc2mem_command !== STORE) begin bad++; $display("FAIL store_ack got=%b/%0d/%0d", dcache_ack, ack_tag, proc2mem_command); end
      adv();
      cyc(NONE, 0, NONE, 0, 0, 6, 64'h66);
      total++; if (dcache_data_valid !== 1'b0 || outstanding_cnt !== 5'd1) begin bad++; $display("FAIL store_no_entry got=dv%b cnt%0d exp=0 1", dcache_data_valid, outstanding_cnt); end
      adv();
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 16; k++) begin
         cyc(NONE, 0, LOAD, 32'h10, 0, 0, 0); adv();
         cyc(NONE, 0, LOAD, 32'h10, 2, 0, 0); adv();
      end
      cyc(NONE, 0, NONE, 0, 0, 0, 0);
      total++; if (outstanding_cnt !== 5'd15) begin bad++; $display("FAIL sat_cnt got=%0d exp=15", outstanding_cnt); end
      adv();
      cyc(NONE, 0, NONE, 0, 0, 2, 64'h2);
      total++; if (dcache_data_valid !== 1'b1) begin bad++; $display("FAIL sat_ret got=%b exp=1", dcache_data_valid); end
      adv();
      cyc(NONE, 0, NONE, 0, 0, 0, 0);
      total++; if (outstanding_cnt !== 5'd14) begin bad++; $display("FAIL sat_dec got=%0d exp=14", outstanding_cnt); end
      adv();
   endtask

   task automatic test_drop();
      cyc(NONE, 0, LOAD, 32'hAB0, 0, 0, 0); adv();
      cyc(NONE, 0, NONE, 0, 0, 0, 0);
      total++; if (proc2mem_command !== LOAD || proc2mem_addr !== 32'hAB0) begin bad++; $display("FAIL drop_hold got=%0d/%0h exp=1/ab0", proc2mem_command, proc2mem_addr); end
      adv();
      cyc(NONE, 0, NONE, 0, 9, 0, 0);
      total++; if (dcache_ack !== 1'b1 || ack_tag !== 4'd9) begin bad++; $display("FAIL drop_ack got=%b/%0d exp=1/9", dcache_ack, ack_tag); end
      adv();
   endtask

   task automatic test_reset_issue();
      cyc(NONE, 0, LOAD, 32'h700, 0, 0, 0); adv();
      cyc(NONE, 0, LOAD, 32'h700, 0, 0, 0);
      total++; if (proc2mem_command !== LOAD) begin bad++; $display("FAIL mid_issue got=%0d exp=1", proc2mem_command); end
      mem2proc_response = 4'd4;
      #1 reset = 1'b1;
      #1;
      total++; if (dcache_ack !== 1'b0 || ack_tag !== 4'd0) begin bad++; $display("FAIL mid_rst_ack got=%b/%0d exp=0/0", dcache_ack, ack_tag); end
      total++; if (proc2mem_command !== NONE || proc2mem_addr !== 32'd0) begin bad++; $display("FAIL mid_rst_drive got=%0d/%0h exp=0/0", proc2mem_command, proc2mem_addr); end
      total++; if (outstanding_cnt !== 5'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", outstanding_cnt); end
      @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
      for (int t = 1; t < 16; t++) begin
         cyc(NONE, 0, NONE, 0, 0, 4'(t), 64'(t));
         if ({icache_data_valid, dcache_data_valid} !== 2'b00) begin
            total++; bad++; $display("FAIL stale_entry tag=%0d got=%b exp=00", t, {icache_data_valid, dcache_data_valid});
         end else total++;
         adv();
      end
   endtask

   task automatic test_starve();
      logic exp_i;
      reset = 1'b1; @(posedge clock); #1; reset = 1'b0; model_reset();
      for (int n = 0; n < 6; n++) begin
         cyc(STORE, 32'h800, STORE, 32'h900, 0, 0, 0); adv();
         cyc(STORE, 32'h800, STORE, 32'h900, 1, 0, 0);
         exp_i = guard && (n == 3);
         total++; if (icache_ack !== exp_i || dcache_ack !== !exp_i) begin bad++; $display("FAIL starve n=%0d got=i%b d%b exp_i=%b", n, icache_ack, dcache_ack, exp_i); end
         adv();
      end
   endtask

   task automatic test_random();
      bit          ip, dp, ia_seen, da_seen;
      logic [1:0]  icmd, dcmd;
      logic [31:0] iad, dad;
      ip = 0; dp = 0; icmd = NONE; dcmd = NONE; iad = 0; dad = 0;
      for (int c = 0; c < 600; c++) begin
         if (!ip && $urandom_range(0, 2) == 0) begin ip = 1; icmd = 2'($urandom_range(1, 2)); iad = $urandom; end
         if (!dp && $urandom_range(0, 2) == 0) begin dp = 1; dcmd = 2'($urandom_range(1, 2)); dad = $urandom; end
         cyc(ip ? icmd : NONE, ip ? iad : 32'd0, dp ? dcmd : NONE, dp ? dad : 32'd0,
             ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0,
             ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
             {$urandom, $urandom});
         total++; if (proc2mem_command !== e_cmd || proc2mem_addr !== e_addr) begin bad++; $display("FAIL rnd_drive c=%0d got=%0d/%0h exp=%0d/%0h", c, proc2mem_command, proc2mem_addr, e_cmd, e_addr); end
         total++; if (icache_ack !== e_iack || dcache_ack !== e_dack || ack_tag !== e_tag) begin bad++; $display("FAIL rnd_ack c=%0d got=%b%b/%0d exp=%b%b/%0d", c, icache_ack, dcache_ack, ack_tag, e_iack, e_dack, e_tag); end
         total++; if (icache_data_valid !== e_ival || dcache_data_valid !== e_dval) begin bad++; $display("FAIL rnd_valid c=%0d got=%b%b exp=%b%b", c, icache_data_valid, dcache_data_valid, e_ival, e_dval); end
         total++; if (cache_data !== e_cdata || cache_tag !== e_ctag) begin bad++; $display("FAIL rnd_ret c=%0d got=%0h/%0d exp=%0h/%0d", c, cache_data, cache_tag, e_cdata, e_ctag); end
         total++; if (outstanding_cnt !== 5'(m_cnt)) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, outstanding_cnt, m_cnt); end
         ia_seen = e_iack; da_seen = e_dack;
         adv();
         if (ia_seen) ip = 0;
         if (da_seen) dp = 0;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_priority_retry();
      test_tag_overlap();
      test_saturation();
      test_drop();
      test_reset_issue();
      test_starve();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
